// File: rtl/vga_scanout_if.sv
// Memory read port between the VGA scanout engine and the shared data memory.
// The scanout side (master) drives the byte address and the memory side (slave)
// returns the addressed byte one clock later.
interface vga_scanout_if;
  logic [31:0] vga_addr;
  logic [7:0]  out_data_vga;

  modport master (
    output vga_addr,
    input  out_data_vga
  );

  modport slave (
    input  vga_addr,
    output out_data_vga
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA scanout engine: generates 640x480@60 Hz style timing from the system
// clock, fetches framebuffer bytes through the memory VGA read port and drives
// a grayscale RGB DAC with sync/blank. The framebuffer is shown in the
// top-left corner of the active area; everything else in the active area is
// black.
module vga_scanout #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int FB_BASE  = 131072
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_scanout_if.master mem_if,
  output logic [7:0]    o_red,
  output logic [7:0]    o_green,
  output logic [7:0]    o_blue,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_blank_n,
  output logic          o_sync_n,
  output logic          o_vga_clk,
  output logic          o_frame_start
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W       = $clog2(H_TOTAL);
  localparam int V_W       = $clog2(V_TOTAL);
  localparam int DIV_W     = $clog2(CLK_DIV);
  localparam int IMG_SHIFT = $clog2(IMG_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT    = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0]   V_ACT    = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0]   HS_FIRST = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0]   VS_FIRST = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [H_W-1:0]   IMG_W_H  = H_W'(IMG_W);
  localparam logic [V_W-1:0]   IMG_H_V  = V_W'(IMG_H);
  localparam logic [31:0]      FB_BASE32 = 32'(FB_BASE);

  // Scan position and pixel-rate divider
  logic [DIV_W-1:0] r_divCnt;
  logic [H_W-1:0]   r_hCnt;
  logic [V_W-1:0]   r_vCnt;

  // Registered memory address and DAC-facing outputs
  logic [31:0] r_vgaAddr;
  logic [7:0]  r_pixel;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_blankN;
  logic        r_vgaClk;
  logic        r_frameStart;

  // Combinational helpers
  logic             w_pixTick;
  logic [DIV_W-1:0] w_divNext;
  logic [H_W-1:0]   w_hNext;
  logic [V_W-1:0]   w_vNext;
  logic             w_inImgNext;
  logic [31:0]      w_addrNext;
  logic             w_inImg;
  logic             w_active;
  logic [7:0]       w_pixel;
  logic             w_hsyncN;
  logic             w_vsyncN;
  logic             w_frameEnd;

  assign w_pixTick = (r_divCnt == DIV_LAST);

  // Next divider and scan position; the raster only moves on a pixel tick
  always_comb begin
    w_divNext = w_pixTick ? '0 : r_divCnt + DIV_W'(1);
    w_hNext   = r_hCnt;
    w_vNext   = r_vCnt;
    if (w_pixTick) begin
      if (r_hCnt == H_LAST) begin
        w_hNext = '0;
        w_vNext = (r_vCnt == V_LAST) ? '0 : r_vCnt + V_W'(1);
      end else begin
        w_hNext = r_hCnt + H_W'(1);
      end
    end
  end

  // Address is formed from the upcoming position so it settles on the same
  // edge as the counters, giving the 1-clk memory a whole pixel period
  always_comb begin
    w_inImgNext = (w_hNext < IMG_W_H) && (w_vNext < IMG_H_V);
    w_addrNext  = FB_BASE32;
    if (w_inImgNext) begin
      w_addrNext = FB_BASE32 + (32'(w_vNext) << IMG_SHIFT) + 32'(w_hNext);
    end
  end

  // Video attributes of the position currently held by the counters
  always_comb begin
    w_active   = (r_hCnt < H_ACT) && (r_vCnt < V_ACT);
    w_inImg    = (r_hCnt < IMG_W_H) && (r_vCnt < IMG_H_V);
    w_pixel    = (w_active && w_inImg) ? mem_if.out_data_vga : 8'h00;
    w_hsyncN   = !((r_hCnt >= HS_FIRST) && (r_hCnt <= HS_LAST));
    w_vsyncN   = !((r_vCnt >= VS_FIRST) && (r_vCnt <= VS_LAST));
    w_frameEnd = w_pixTick && (r_hCnt == H_LAST) && (r_vCnt == V_LAST);
  end

  // Divider and raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divCnt <= '0;
      r_hCnt   <= '0;
      r_vCnt   <= '0;
    end else begin
      r_divCnt <= w_divNext;
      r_hCnt   <= w_hNext;
      r_vCnt   <= w_vNext;
    end
  end

  // Memory read address, refreshed every clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vgaAddr <= FB_BASE32;
    end else begin
      r_vgaAddr <= w_addrNext;
    end
  end

  // Output stage: on the tick that leaves a position, publish that position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel  <= 8'h00;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
      r_blankN <= 1'b0;
    end else if (w_pixTick) begin
      r_pixel  <= w_pixel;
      r_hsync  <= w_hsyncN;
      r_vsync  <= w_vsyncN;
      r_blankN <= w_active;
    end
  end

  // DAC sample clock and end-of-frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vgaClk     <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_vgaClk     <= (w_divNext >= DIV_HALF);
      r_frameStart <= w_frameEnd;
    end
  end

  assign mem_if.vga_addr = r_vgaAddr;
  assign o_red           = r_pixel;
  assign o_green         = r_pixel;
  assign o_blue          = r_pixel;
  assign o_hsync         = r_hsync;
  assign o_vsync         = r_vsync;
  assign o_blank_n       = r_blankN;
  assign o_sync_n        = 1'b0;
  assign o_vga_clk       = r_vgaClk;
  assign o_frame_start   = r_frameStart;

endmodule

// File: tb/tb_vga_scanout.sv
// Testbench for vga_scanout. dutA uses the full 640x480 timing for reset,
// line timing, addressing and mid-line reset. dutB uses a shrunken raster
// (48x32 total, 16x16 image, base with a non-zero low byte) so whole frames
// fit in a short run. Edge numbers count clk rising edges since rst_n rose.
module tb_vga_scanout;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int edgeCnt = 0;

  vga_scanout_if memA ();
  vga_scanout_if memB ();

  logic [7:0] aRed, aGreen, aBlue, bRed, bGreen, bBlue;
  logic aHsync, aVsync, aBlank, aSyncN, aVgaClk, aFrame;
  logic bHsync, bVsync, bBlank, bSyncN, bVgaClk, bFrame;

  vga_scanout dutA (
    .clk(clk), .rst_n(rst_n), .mem_if(memA),
    .o_red(aRed), .o_green(aGreen), .o_blue(aBlue),
    .o_hsync(aHsync), .o_vsync(aVsync), .o_blank_n(aBlank),
    .o_sync_n(aSyncN), .o_vga_clk(aVgaClk), .o_frame_start(aFrame)
  );

  vga_scanout #(
    .CLK_DIV(2), .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .IMG_W(16), .IMG_H(16), .FB_BASE(131136)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .mem_if(memB),
    .o_red(bRed), .o_green(bGreen), .o_blue(bBlue),
    .o_hsync(bHsync), .o_vsync(bVsync), .o_blank_n(bBlank),
    .o_sync_n(bSyncN), .o_vga_clk(bVgaClk), .o_frame_start(bFrame)
  );

  always #5 clk = ~clk;

  // Memory models: return the low address byte one clock later
  always @(posedge clk) begin
    memA.out_data_vga <= memA.vga_addr[7:0];
    memB.out_data_vga <= memB.vga_addr[7:0];
  end

  // Edge counter since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edgeCnt <= 0;
    else        edgeCnt <= edgeCnt + 1;
  end

  task automatic waitEdge(input int k);
    while (edgeCnt < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    total++; if (aRed !== 8'h00) begin bad++; $display("[TB] FAIL reset_red: got %h expected 00", aRed); end
    total++; if (aGreen !== 8'h00) begin bad++; $display("[TB] FAIL reset_green: got %h expected 00", aGreen); end
    total++; if (aBlue !== 8'h00) begin bad++; $display("[TB] FAIL reset_blue: got %h expected 00", aBlue); end
    total++; if (aHsync !== 1'b1) begin bad++; $display("[TB] FAIL reset_hsync: got %b expected 1", aHsync); end
    total++; if (aVsync !== 1'b1) begin bad++; $display("[TB] FAIL reset_vsync: got %b expected 1", aVsync); end
    total++; if (aBlank !== 1'b0) begin bad++; $display("[TB] FAIL reset_blank_n: got %b expected 0", aBlank); end
    total++; if (aSyncN !== 1'b0) begin bad++; $display("[TB] FAIL reset_sync_n: got %b expected 0", aSyncN); end
    total++; if (aVgaClk !== 1'b0) begin bad++; $display("[TB] FAIL reset_vga_clk: got %b expected 0", aVgaClk); end
    total++; if (aFrame !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_start: got %b expected 0", aFrame); end
    total++; if (memA.vga_addr !== 32'd131072) begin bad++; $display("[TB] FAIL reset_addr: got %0d expected 131072", memA.vga_addr); end
    total++; if (memB.vga_addr !== 32'd131136) begin bad++; $display("[TB] FAIL reset_addr_b: got %0d expected 131136", memB.vga_addr); end
    rst_n = 1'b1;
    waitEdge(1);
    total++; if (memA.vga_addr !== 32'd131072) begin bad++; $display("[TB] FAIL edge1_addr: got %0d expected 131072", memA.vga_addr); end
    total++; if (aVgaClk !== 1'b1) begin bad++; $display("[TB] FAIL edge1_vga_clk: got %b expected 1", aVgaClk); end
    total++; if (aBlank !== 1'b0) begin bad++; $display("[TB] FAIL edge1_blank_n: got %b expected 0", aBlank); end
    waitEdge(2);
    total++; if (aBlank !== 1'b1) begin bad++; $display("[TB] FAIL edge2_blank_n: got %b expected 1", aBlank); end
    total++; if (aVgaClk !== 1'b0) begin bad++; $display("[TB] FAIL edge2_vga_clk: got %b expected 0", aVgaClk); end
    total++; if (memA.vga_addr !== 32'd131073) begin bad++; $display("[TB] FAIL edge2_addr: got %0d expected 131073", memA.vga_addr); end
  endtask

  task automatic test_line_timing();
    int fallAt[2];
    int lowLen[2];
    int blankCnt[2];
    int nFall;
    int vLow;
    logic prevH;
    fallAt = '{-1, -1};
    lowLen = '{0, 0};
    blankCnt = '{0, 0};
    nFall = 0;
    vLow = 0;
    prevH = 1'b1;
    doReset();
    for (int e = 1; e <= 3200; e++) begin
      waitEdge(e);
      if (prevH && !aHsync) begin
        if (nFall < 2) fallAt[nFall] = e;
        nFall++;
      end
      if (!aHsync && nFall >= 1 && nFall <= 2) lowLen[nFall-1]++;
      if (aBlank) blankCnt[(e-1)/1600]++;
      if (!aVsync) vLow++;
      prevH = aHsync;
    end
    total++; if (nFall !== 2) begin bad++; $display("[TB] FAIL line_hsync_falls: got %0d expected 2", nFall); end
    total++; if (fallAt[0] !== 1314) begin bad++; $display("[TB] FAIL line_first_fall: got %0d expected 1314", fallAt[0]); end
    total++; if (fallAt[1] - fallAt[0] !== 1600) begin bad++; $display("[TB] FAIL line_period: got %0d expected 1600", fallAt[1] - fallAt[0]); end
    total++; if (lowLen[0] !== 192) begin bad++; $display("[TB] FAIL line_hsync_len0: got %0d expected 192", lowLen[0]); end
    total++; if (lowLen[1] !== 192) begin bad++; $display("[TB] FAIL line_hsync_len1: got %0d expected 192", lowLen[1]); end
    total++; if (blankCnt[0] !== 1280) begin bad++; $display("[TB] FAIL line_blank0: got %0d expected 1280", blankCnt[0]); end
    total++; if (blankCnt[1] !== 1280) begin bad++; $display("[TB] FAIL line_blank1: got %0d expected 1280", blankCnt[1]); end
    total++; if (vLow !== 0) begin bad++; $display("[TB] FAIL line_vsync_quiet: got %0d expected 0", vLow); end
  endtask

  task automatic test_addressing();
    doReset();
    waitEdge(6436);
    total++; if (memA.vga_addr !== 32'd132114) begin bad++; $display("[TB] FAIL addr_12_04: got %0d expected 132114", memA.vga_addr); end
    total++; if (aRed !== 8'h11) begin bad++; $display("[TB] FAIL rgb_11_04: got %h expected 11", aRed); end
    waitEdge(6438);
    total++; if (aRed !== 8'h12) begin bad++; $display("[TB] FAIL red_12_04: got %h expected 12", aRed); end
    total++; if (aGreen !== 8'h12) begin bad++; $display("[TB] FAIL green_12_04: got %h expected 12", aGreen); end
    total++; if (aBlue !== 8'h12) begin bad++; $display("[TB] FAIL blue_12_04: got %h expected 12", aBlue); end
    total++; if (aBlank !== 1'b1) begin bad++; $display("[TB] FAIL blank_12_04: got %b expected 1", aBlank); end
    waitEdge(16510);
    total++; if (memA.vga_addr !== 32'd133887) begin bad++; $display("[TB] FAIL addr_255_10: got %0d expected 133887", memA.vga_addr); end
    waitEdge(16512);
    total++; if (aRed !== 8'hFF) begin bad++; $display("[TB] FAIL rgb_255_10: got %h expected ff", aRed); end
    total++; if (memA.vga_addr !== 32'd131072) begin bad++; $display("[TB] FAIL addr_256_10: got %0d expected 131072", memA.vga_addr); end
    waitEdge(16514);
    total++; if (aRed !== 8'h00) begin bad++; $display("[TB] FAIL rgb_256_10: got %h expected 00", aRed); end
    waitEdge(16600);
    total++; if (memA.vga_addr !== 32'd131072) begin bad++; $display("[TB] FAIL addr_300_10: got %0d expected 131072", memA.vga_addr); end
    waitEdge(16602);
    total++; if (aRed !== 8'h00) begin bad++; $display("[TB] FAIL rgb_300_10: got %h expected 00", aRed); end
    total++; if (aBlank !== 1'b1) begin bad++; $display("[TB] FAIL blank_300_10: got %b expected 1", aBlank); end
    total++; if (aHsync !== 1'b1) begin bad++; $display("[TB] FAIL hsync_300_10: got %b expected 1", aHsync); end
    waitEdge(17402);
    total++; if (aBlank !== 1'b0) begin bad++; $display("[TB] FAIL blank_700_10: got %b expected 0", aBlank); end
    total++; if (aRed !== 8'h00) begin bad++; $display("[TB] FAIL rgb_700_10: got %h expected 00", aRed); end
    total++; if (aHsync !== 1'b0) begin bad++; $display("[TB] FAIL hsync_700_10: got %b expected 0", aHsync); end
  endtask

  task automatic test_midline_reset();
    int fallAt;
    fallAt = -1;
    doReset();
    waitEdge(2401);
    total++; if (aBlank !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_blank: got %b expected 1", aBlank); end
    total++; if (aVgaClk !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_vga_clk: got %b expected 1", aVgaClk); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (aBlank !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_blank: got %b expected 0", aBlank); end
    total++; if (aVgaClk !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_vga_clk: got %b expected 0", aVgaClk); end
    total++; if (aHsync !== 1'b1) begin bad++; $display("[TB] FAIL mid_rst_hsync: got %b expected 1", aHsync); end
    total++; if (memA.vga_addr !== 32'd131072) begin bad++; $display("[TB] FAIL mid_rst_addr: got %0d expected 131072", memA.vga_addr); end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    waitEdge(2);
    total++; if (memA.vga_addr !== 32'd131073) begin bad++; $display("[TB] FAIL mid_restart_addr: got %0d expected 131073", memA.vga_addr); end
    for (int e = 3; e <= 1400; e++) begin
      waitEdge(e);
      if (!aHsync) begin
        fallAt = e;
        break;
      end
    end
    total++; if (fallAt !== 1314) begin bad++; $display("[TB] FAIL mid_first_hsync: got %0d expected 1314", fallAt); end
  endtask

  task automatic test_frame_timing();
    int fallAt[2];
    int lowLen[2];
    int fsAt[2];
    int nFall;
    int fsCnt;
    logic prevV;
    fallAt = '{-1, -1};
    lowLen = '{0, 0};
    fsAt = '{-1, -1};
    nFall = 0;
    fsCnt = 0;
    prevV = 1'b1;
    doReset();
    for (int e = 1; e <= 6200; e++) begin
      waitEdge(e);
      if (prevV && !bVsync) begin
        if (nFall < 2) fallAt[nFall] = e;
        nFall++;
      end
      if (!bVsync && nFall >= 1 && nFall <= 2) lowLen[nFall-1]++;
      if (bFrame) begin
        if (fsCnt < 2) fsAt[fsCnt] = e;
        fsCnt++;
      end
      prevV = bVsync;
    end
    total++; if (nFall !== 2) begin bad++; $display("[TB] FAIL frame_vsync_falls: got %0d expected 2", nFall); end
    total++; if (fallAt[0] !== 2498) begin bad++; $display("[TB] FAIL frame_first_fall: got %0d expected 2498", fallAt[0]); end
    total++; if (fallAt[1] - fallAt[0] !== 3072) begin bad++; $display("[TB] FAIL frame_period: got %0d expected 3072", fallAt[1] - fallAt[0]); end
    total++; if (lowLen[0] !== 192) begin bad++; $display("[TB] FAIL frame_vsync_len0: got %0d expected 192", lowLen[0]); end
    total++; if (lowLen[1] !== 192) begin bad++; $display("[TB] FAIL frame_vsync_len1: got %0d expected 192", lowLen[1]); end
    total++; if (fsCnt !== 2) begin bad++; $display("[TB] FAIL frame_start_count: got %0d expected 2", fsCnt); end
    total++; if (fsAt[0] !== 3072) begin bad++; $display("[TB] FAIL frame_start_0: got %0d expected 3072", fsAt[0]); end
    total++; if (fsAt[1] !== 6144) begin bad++; $display("[TB] FAIL frame_start_1: got %0d expected 6144", fsAt[1]); end
  endtask

  task automatic test_image_edges();
    doReset();
    waitEdge(74);
    total++; if (bHsync !== 1'b0) begin bad++; $display("[TB] FAIL b_hsync_36: got %b expected 0", bHsync); end
    waitEdge(88);
    total++; if (bHsync !== 1'b0) begin bad++; $display("[TB] FAIL b_hsync_43: got %b expected 0", bHsync); end
    waitEdge(90);
    total++; if (bHsync !== 1'b1) begin bad++; $display("[TB] FAIL b_hsync_44: got %b expected 1", bHsync); end
    waitEdge(328);
    total++; if (memB.vga_addr !== 32'd131136) begin bad++; $display("[TB] FAIL b_addr_20_3: got %0d expected 131136", memB.vga_addr); end
    waitEdge(330);
    total++; if (bRed !== 8'h00) begin bad++; $display("[TB] FAIL b_rgb_20_3: got %h expected 00", bRed); end
    total++; if (bBlank !== 1'b1) begin bad++; $display("[TB] FAIL b_blank_20_3: got %b expected 1", bBlank); end
    waitEdge(682);
    total++; if (memB.vga_addr !== 32'd131253) begin bad++; $display("[TB] FAIL b_addr_5_7: got %0d expected 131253", memB.vga_addr); end
    waitEdge(684);
    total++; if (bRed !== 8'hB5) begin bad++; $display("[TB] FAIL b_red_5_7: got %h expected b5", bRed); end
    total++; if (bBlue !== 8'hB5) begin bad++; $display("[TB] FAIL b_blue_5_7: got %h expected b5", bBlue); end
    waitEdge(1470);
    total++; if (memB.vga_addr !== 32'd131391) begin bad++; $display("[TB] FAIL b_addr_15_15: got %0d expected 131391", memB.vga_addr); end
    waitEdge(1472);
    total++; if (bGreen !== 8'h3F) begin bad++; $display("[TB] FAIL b_green_15_15: got %h expected 3f", bGreen); end
    waitEdge(1926);
    total++; if (memB.vga_addr !== 32'd131136) begin bad++; $display("[TB] FAIL b_addr_3_20: got %0d expected 131136", memB.vga_addr); end
    waitEdge(1928);
    total++; if (bRed !== 8'h00) begin bad++; $display("[TB] FAIL b_rgb_3_20: got %h expected 00", bRed); end
    total++; if (bBlank !== 1'b1) begin bad++; $display("[TB] FAIL b_blank_3_20: got %b expected 1", bBlank); end
    waitEdge(2408);
    total++; if (bBlank !== 1'b0) begin bad++; $display("[TB] FAIL b_blank_3_25: got %b expected 0", bBlank); end
  endtask

  // Run every scenario in order, then report
  initial begin
    $display("[TB] starting vga_scanout bench");
    test_reset();
    test_line_timing();
    test_addressing();
    test_midline_reset();
    test_frame_timing();
    test_image_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display-side consumer of the shared data memory. Generates 640x480@60 Hz VGA timing from the system clock, drives `vga_addr` into the memory's VGA read port, and turns the returned 8-bit pixel (`out_data_vga`) into grayscale RGB plus sync and blank signals for the video DAC. It shows an IMG_W x IMG_H framebuffer in the top-left corner of the screen. The rest of the active area is black.

## Interface
- CLK_DIV, 2: system clocks per pixel; must be >= 2 (50 MHz -> 25 MHz pixel rate)
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48: horizontal timing in pixels; H_TOTAL = 800
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33: vertical timing in lines; V_TOTAL = 525
- IMG_W, 256: framebuffer width in pixels; must be a power of two
- IMG_H, 256: framebuffer height in lines
- FB_BASE, 131072: byte address of framebuffer pixel (0,0) in the VGA address space (memory block 2)
- clk  in  1  system clock; every register is updated on its rising edge
- rst_n  in  1  asynchronous reset, active-low
- vga_addr  out  32  byte address to the memory VGA port
- out_data_vga  in  8  pixel byte from memory, valid 1 clk after vga_addr
- red, green, blue  out  8 each  grayscale pixel, R = G = B
- hsync, vsync  out  1 each  active-low sync
- blank_n  out  1  1 = active video area
- sync_n  out  1  tied 0 (no sync-on-green)
- vga_clk  out  1  DAC sample clock, one period per pixel
- frame_start  out  1  one-clk pulse per frame

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick = (div_cnt == CLK_DIV-1).
- Counters: h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1 advance only on pix_tick.
  - h wraps to 0 and increments v.
  - v wraps to 0 after V_TOTAL-1.
- in_img = h_cnt < IMG_W && v_cnt < IMG_H.
- Address: vga_addr is registered every clk.
  - in_img: FB_BASE + (v_cnt << log2(IMG_W)) + h_cnt, computed in 32 bits with no saturation.
  - Otherwise: FB_BASE.
- Output stage, registered on pix_tick, describing the position the counters hold before the tick:
  - hsync = 0 iff h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync = 0 iff v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
  - blank_n = (h < H_ACTIVE && v < V_ACTIVE).
  - red/green/blue = out_data_vga when in_img, else 0. Blanking forces 0.
- vga_clk: registered; next value = (div_cnt_next >= CLK_DIV/2).
- frame_start: registered. High for exactly one clk following the pix_tick where h = H_TOTAL-1 and v = V_TOTAL-1.
- The block never writes memory and has no CPU-side ports.

## Timing
- Reset values while rst_n = 0, applied immediately (asynchronous):
  - div_cnt, h_cnt, v_cnt = 0
  - vga_addr = FB_BASE
  - red, green, blue = 0
  - hsync = 1, vsync = 1
  - blank_n = 0, vga_clk = 0, frame_start = 0
- After rst_n rises, the first pix_tick occurs on clk edge CLK_DIV.
- Memory latency is 1 clk; this is why CLK_DIV >= 2 is required. The address for position (h,v) is stable for CLK_DIV clks, so out_data_vga is valid before the pix_tick that leaves (h,v).
- Outputs lag the counters by exactly one pixel period. All outputs for a given pixel change on the same clk edge.
- With CLK_DIV = 2, vga_clk rises 1 clk after the output update, so data is mid-stable at the DAC edge.
- Line = H_TOTAL*CLK_DIV = 1600 clk. Frame = 525 lines = 840000 clk.
- Reset mid-frame: everything returns to reset values at once, and the scan restarts at (0,0) with no partial-frame recovery.

## Test plan
- Memory model for all scenarios: returns the low byte of vga_addr, registered 1 clk.
- Reset: hold rst_n = 0 for 10 clk -> all outputs at reset values. Release -> first pix_tick at clk 2, and vga_addr = 131072 at (0,0).
- Line timing: run 2 lines -> hsync low for exactly 192 clk; hsync falling-edge period = 1600 clk; blank_n high for 1280 clk per line.
- Frame timing: run 2 frames -> vsync low for exactly 3200 clk, falling edges 840000 clk apart, exactly one frame_start per frame.
- Addressing: at h = 0x12, v = 0x34 -> vga_addr = 144402, and one pixel period later red = green = blue = 0x12, blank_n = 1.
- Outside image:
  - h = 300, v = 10 -> rgb = 0, blank_n = 1, vga_addr = 131072.
  - h = 700 -> blank_n = 0, rgb = 0.
  - v = 300 with h < 256 -> rgb = 0.
- Reset mid-line: drop rst_n at h = 400, v = 100 for 3 clk -> outputs reset within the same clk. After release, hsync first falls 656*2 + 2 clk later.
